modular_multiplier: RTL and testbench



---
 rtl/modular_multiplier.sv | 86 ++++++++
 tb/tb_modular_multiplier.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/modular_multiplier.sv
// modular_multiplier: R = (a*b) mod p, bit-serial MSB-first interleaved double-and-add.
// One multiplier bit per clock; operands are latched at start so inputs may change during CALC.
module modular_multiplier #(
    parameter int Data_Width = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [Data_Width-1:0] i_a,
    input  logic [Data_Width-1:0] i_b,
    input  logic [Data_Width-1:0] i_p,
    output logic [Data_Width-1:0] o_R,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    localparam int IW = $clog2(Data_Width);
    typedef enum logic {IDLE, CALC} state_t;
    state_t st_q, st_d;
    logic [Data_Width-1:0] a_q, a_d, b_q, b_d, p_q, p_d, acc_q, acc_d, r_q, r_d;
    logic [IW-1:0] i_q, i_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [Data_Width:0] pe, d2, s1;
    logic [Data_Width-1:0] dr, s;
    logic bad, go, last;

    // Compares run on Data_Width+1 bits so the doubling/addition carry is never lost.
    always_comb begin
        pe = {1'b0, p_q};
        d2 = {acc_q, 1'b0};
        dr = d2 >= pe ? Data_Width'(d2 - pe) : d2[Data_Width-1:0];
        s1 = {1'b0, dr} + {1'b0, a_q};
        s  = !b_q[i_q] ? dr : s1 >= pe ? Data_Width'(s1 - pe) : s1[Data_Width-1:0];
    end

    assign bad  = i_a >= i_p || i_b >= i_p || i_p[Data_Width-1:1] == '0;
    assign go   = st_q == IDLE && i_start;
    assign last = st_q == CALC && i_q == '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q   <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            acc_q  <= '0;
            r_q    <= '0;
            i_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            acc_q  <= acc_d;
            r_q    <= r_d;
            i_q    <= i_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        st_d = st_q == IDLE ? (i_start && !bad ? CALC : IDLE) : (last ? IDLE : CALC);
    end

    always_comb begin
        a_d    = go ? i_a : a_q;
        b_d    = go ? i_b : b_q;
        p_d    = go ? i_p : p_q;
        acc_d  = go ? '0 : st_q == CALC ? s : acc_q;
        i_d    = go ? IW'(Data_Width - 1) : st_q == CALC ? i_q - IW'(1) : i_q;
        r_d    = go ? (bad ? '0 : r_q) : last ? s : r_q;
        err_d  = go ? bad : err_q;
        done_d = (go && bad) || last;
        busy_d = st_d == CALC;
    end

    assign o_R    = r_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;
endmodule

// File: tb/tb_modular_multiplier.sv
// tb_modular_multiplier: vector table, hand-written corner sequences and random ops
// against (a*b)%p, on an 8-bit and a 256-bit instance.
module tb_modular_multiplier;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic st8, busy8, done8, err8;
    logic [7:0] a8, b8, p8, r8;
    logic st256, busy256, done256, err256;
    logic [255:0] a256, b256, p256, r256;

    modular_multiplier #(.Data_Width(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(st8), .i_a(a8), .i_b(b8), .i_p(p8),
        .o_R(r8), .o_busy(busy8), .o_done(done8), .o_err(err8));

    modular_multiplier #(.Data_Width(256)) dut256 (
        .i_clk(clk), .i_rst(rst), .i_start(st256), .i_a(a256), .i_b(b256), .i_p(p256),
        .o_R(r256), .o_busy(busy256), .o_done(done256), .o_err(err256));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a, b, p, r;
        logic       e;
        int         lat;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Latency counts edges from the start edge to the done edge inclusive.
    task automatic op8(input logic [7:0] a, b, p, output logic [7:0] r, output logic e,
                       output int lat, output int bsy);
        @(negedge clk);
        a8 = a; b8 = b; p8 = p; st8 = 1'b1;
        @(posedge clk);
        lat = 1; bsy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            st8 = 1'b0;
            if (done8) break;
            bsy += int'(busy8);
            @(posedge clk);
            lat++;
        end
        if (!done8) lat = -1;
        check("busy_at_done8", {255'b0, busy8}, 256'd0);
        r = r8; e = err8;
        @(negedge clk);
        check("done_pulse8", {255'b0, done8}, 256'd0);
    endtask

    task automatic op256(input logic [255:0] a, b, p, output logic [255:0] r, output int lat);
        @(negedge clk);
        a256 = a; b256 = b; p256 = p; st256 = 1'b1;
        @(posedge clk);
        lat = 1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            st256 = 1'b0;
            if (done256) break;
            @(posedge clk);
            lat++;
        end
        if (!done256) lat = -1;
        r = r256;
        check("err256", {255'b0, err256}, 256'd0);
    endtask

    initial begin
        logic [7:0] r, ra, rb, rp;
        logic e;
        int lat, bsy, nd, first_done, ovl;
        int dq[$];
        logic [255:0] bigp, rr, ba, bb;
        logic [511:0] prod;

        vt[0]  = '{8'd3,   8'd86,  8'd251, 8'd7,   1'b0, 9};
        vt[1]  = '{8'd3,   8'd84,  8'd251, 8'd1,   1'b0, 9};
        vt[2]  = '{8'd250, 8'd250, 8'd251, 8'd1,   1'b0, 9};
        vt[3]  = '{8'd0,   8'd200, 8'd251, 8'd0,   1'b0, 9};
        vt[4]  = '{8'd251, 8'd5,   8'd251, 8'd0,   1'b1, 1};
        vt[5]  = '{8'd3,   8'd5,   8'd1,   8'd0,   1'b1, 1};
        vt[6]  = '{8'd3,   8'd255, 8'd251, 8'd0,   1'b1, 1};
        vt[7]  = '{8'd1,   8'd1,   8'd2,   8'd1,   1'b0, 9};
        vt[8]  = '{8'd254, 8'd254, 8'd255, 8'd1,   1'b0, 9};
        vt[9]  = '{8'd200, 8'd100, 8'd251, 8'd171, 1'b0, 9};
        vt[10] = '{8'd128, 8'd2,   8'd251, 8'd5,   1'b0, 9};
        vt[11] = '{8'd7,   8'd3,   8'd7,   8'd0,   1'b1, 1};

        st8 = 0; a8 = 0; b8 = 0; p8 = 0;
        st256 = 0; a256 = 0; b256 = 0; p256 = 0;
        rst = 1'b1;
        #12;
        check("rst_R8", r8, 0);
        check("rst_flags8", {busy8, done8, err8}, 0);
        check("rst_R256", r256, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[k]) begin
            op8(vt[k].a, vt[k].b, vt[k].p, r, e, lat, bsy);
            check($sformatf("vec%0d_R", k), r, vt[k].r);
            check($sformatf("vec%0d_err", k), e, vt[k].e);
            check($sformatf("vec%0d_lat", k), lat, vt[k].lat);
            check($sformatf("vec%0d_busy", k), bsy, vt[k].e ? 0 : 8);
        end

        // Inputs and start toggled while calculating must not disturb the result.
        @(negedge clk);
        a8 = 3; b8 = 86; p8 = 251; st8 = 1;
        @(posedge clk);
        nd = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (n < 6) begin
                a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom);
                st8 = n[0];
            end else st8 = 0;
            if (done8) begin
                nd++;
                r = r8;
            end
        end
        check("interf_ndone", nd, 1);
        check("interf_R", r, 7);

        // Start held high: results every 9 edges, done and busy never together.
        @(negedge clk);
        a8 = 3; b8 = 86; p8 = 251; st8 = 1;
        ovl = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8 && busy8) ovl++;
            if (done8) begin
                dq.push_back(n);
                check($sformatf("held_R%0d", dq.size()), r8, 7);
            end
        end
        st8 = 0;
        first_done = dq.size() > 0 ? dq[0] : -1;
        check("held_first", first_done, 8);
        check("held_gap", dq.size() >= 2 ? dq[1] - dq[0] : -1, 9);
        check("held_overlap", ovl, 0);
        for (int n = 0; n < 20 && busy8; n++) @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the 4th CALC cycle discards the operation.
        @(negedge clk);
        a8 = 3; b8 = 86; p8 = 251; st8 = 1;
        @(posedge clk);
        @(negedge clk);
        st8 = 0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst = 1;
        #1;
        check("arst_R", r8, 0);
        check("arst_flags", {busy8, done8, err8}, 0);
        @(negedge clk);
        rst = 0;
        nd = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            nd += int'(done8) + int'(busy8);
        end
        check("arst_no_done", nd, 0);
        op8(3, 84, 251, r, e, lat, bsy);
        check("post_rst_R", r, 1);
        check("post_rst_lat", lat, 9);

        for (int k = 0; k < 40; k++) begin
            rp = 8'($urandom_range(255, 2));
            ra = 8'($urandom_range(int'(rp) - 1, 0));
            rb = 8'($urandom_range(int'(rp) - 1, 0));
            op8(ra, rb, rp, r, e, lat, bsy);
            check($sformatf("rnd%0d_R", k), r, (int'(ra) * int'(rb)) % int'(rp));
            check($sformatf("rnd%0d_err", k), e, 0);
        end

        bigp = {{192{1'b1}}, 64'hFFFFFFFEFFFFFC2F};
        op256(bigp - 1, bigp - 1, bigp, rr, lat);
        check("w256_pm1_R", rr, 1);
        check("w256_lat", lat, 257);
        op256({1'b1, 255'b0}, 256'd2, bigp, rr, lat);
        check("w256_carry_R", rr, 256'h1000003D1);
        for (int k = 0; k < 3; k++) begin
            ba = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            bb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (ba >= bigp) ba = ba - bigp;
            if (bb >= bigp) bb = bb - bigp;
            prod = {256'b0, ba} * {256'b0, bb};
            op256(ba, bb, bigp, rr, lat);
            check($sformatf("w256_rnd%0d", k), rr, 256'(prod % {256'b0, bigp}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
